hazard_stall_ctrl: RTL and testbench

- Resolution side of the hazard path. Hazard detection raises a flag when a source register matches a destination register; this block acts on that flag.
- Sits beside the ID stage. It tracks in-flight register writes in a shadow pipeline (scoreboard) and generates:
  - stall for PC and IF/ID,
  - a bubble into EX,
  - per-operand forwarding selects.
- Registers are 3-bit addressed (8 GPRs, all writable).

---
 rtl/proc_pkg.sv | 21 ++
 rtl/hazard_match.sv | 27 ++
 rtl/hazard_stall_ctrl.sv | 95 +++++++++
 tb/tb_hazard_stall_ctrl.sv | 252 +++++++++++++++++++++++++
 4 files changed

// File: rtl/proc_pkg.sv
// Shared processor definitions: register addressing, forward-select encoding
// and the scoreboard entry used by the hazard resolution logic.
package proc_pkg;

    localparam int REG_AW   = 3;
    localparam int NUM_REGS = 8;

    localparam logic [2:0] FWD_RF = 3'd0;

    // Forward select for the result held in shadow stage k.
    function automatic logic [2:0] FWD_STG(input int k);
        return 3'(k + 1);
    endfunction

    typedef struct packed {
        logic              v;
        logic [REG_AW-1:0] dest;
        logic              is_load;
    } sb_entry_t;

endpackage

// File: rtl/hazard_match.sv
// Compares one ID source register against every shadow-pipeline entry and
// priority-encodes the youngest matching producer as a forward select.
module hazard_match
    import proc_pkg::*;
#(
    parameter int WB_LAT = 3
) (
    input  logic [REG_AW-1:0]           src,
    input  logic                        src_en,
    input  sb_entry_t [WB_LAT-1:0]      sb,
    output logic      [WB_LAT-1:0]      match,
    output logic      [2:0]             fwd_idx
);

    // Walk oldest to youngest so the lowest matching stage is left in fwd_idx.
    always_comb begin
        match   = '0;
        fwd_idx = FWD_RF;
        for (int k = WB_LAT - 1; k >= 0; k--) begin
            match[k] = src_en & sb[k].v & (sb[k].dest == src);
            if (match[k]) begin
                fwd_idx = FWD_STG(k);
            end
        end
    end

endmodule

// File: rtl/hazard_stall_ctrl.sv
// Hazard resolution beside the ID stage: shadow scoreboard of in-flight writes,
// stall/bubble/issue generation, forward selects and a saturating stall counter.
module hazard_stall_ctrl
    import proc_pkg::*;
#(
    parameter int WB_LAT = 3,
    parameter int FWD_EN = 1,
    parameter int CNT_W  = 16
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               id_valid,
    input  logic [REG_AW-1:0]  id_src_a,
    input  logic               id_src_a_en,
    input  logic [REG_AW-1:0]  id_src_b,
    input  logic               id_src_b_en,
    input  logic [REG_AW-1:0]  id_dest,
    input  logic               id_dest_we,
    input  logic               id_is_load,
    input  logic               flush,
    output logic               stall,
    output logic               bubble,
    output logic               issue,
    output logic [2:0]         fwd_a,
    output logic [2:0]         fwd_b,
    output logic [CNT_W-1:0]   stall_cnt
);

    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);
    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    sb_entry_t [WB_LAT-1:0] sb;
    logic      [WB_LAT-1:0] match_a;
    logic      [WB_LAT-1:0] match_b;
    logic      [2:0]        fwd_idx_a;
    logic      [2:0]        fwd_idx_b;
    logic                   hazard;

    hazard_match #(.WB_LAT(WB_LAT)) u_match_a (
        .src     (id_src_a),
        .src_en  (id_src_a_en),
        .sb      (sb),
        .match   (match_a),
        .fwd_idx (fwd_idx_a)
    );

    hazard_match #(.WB_LAT(WB_LAT)) u_match_b (
        .src     (id_src_b),
        .src_en  (id_src_b_en),
        .sb      (sb),
        .match   (match_b),
        .fwd_idx (fwd_idx_b)
    );

    // With forwarding only a load still in stage 0 has no result to forward yet.
    always_comb begin
        if (FWD_EN != 0) begin
            hazard = (match_a[0] | match_b[0]) & sb[0].is_load;
        end else begin
            hazard = (|match_a) | (|match_b);
        end
    end

    always_comb begin
        stall  = id_valid & ~flush & hazard;
        issue  = id_valid & ~flush & ~hazard;
        bubble = stall | flush | ~id_valid;
        fwd_a  = FWD_RF;
        fwd_b  = FWD_RF;
        if ((FWD_EN != 0) && !stall) begin
            fwd_a = fwd_idx_a;
            fwd_b = fwd_idx_b;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sb <= '0;
        end else begin
            sb[0] <= '{v: issue & id_dest_we, dest: id_dest, is_load: id_is_load};
            for (int k = 1; k < WB_LAT; k++) begin
                sb[k] <= sb[k-1];
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stall_cnt <= '0;
        end else if (stall && (stall_cnt != CNT_MAX)) begin
            stall_cnt <= stall_cnt + CNT_ONE;
        end
    end

endmodule

// File: tb/tb_hazard_stall_ctrl.sv
// Directed bench for hazard_stall_ctrl: forwarding, load-use, no-forwarding,
// flush, reset and counter saturation scenarios on three configurations.
module tb_hazard_stall_ctrl;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       id_valid = 1'b0;
    logic [2:0] id_src_a = '0;
    logic       id_src_a_en = 1'b0;
    logic [2:0] id_src_b = '0;
    logic       id_src_b_en = 1'b0;
    logic [2:0] id_dest = '0;
    logic       id_dest_we = 1'b0;
    logic       id_is_load = 1'b0;
    logic       flush = 1'b0;

    logic s1, bb1, i1, s0, bb0, i0, s7, bb7, i7;
    logic [2:0] fa1, fb1, fa0, fb0, fa7, fb7;
    logic [15:0] c1, c0, c7;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    hazard_stall_ctrl #(.WB_LAT(3), .FWD_EN(1), .CNT_W(16)) dut1 (
        .clk(clk), .rst_n(rst_n), .id_valid(id_valid),
        .id_src_a(id_src_a), .id_src_a_en(id_src_a_en),
        .id_src_b(id_src_b), .id_src_b_en(id_src_b_en),
        .id_dest(id_dest), .id_dest_we(id_dest_we), .id_is_load(id_is_load),
        .flush(flush), .stall(s1), .bubble(bb1), .issue(i1),
        .fwd_a(fa1), .fwd_b(fb1), .stall_cnt(c1)
    );

    hazard_stall_ctrl #(.WB_LAT(3), .FWD_EN(0), .CNT_W(16)) dut0 (
        .clk(clk), .rst_n(rst_n), .id_valid(id_valid),
        .id_src_a(id_src_a), .id_src_a_en(id_src_a_en),
        .id_src_b(id_src_b), .id_src_b_en(id_src_b_en),
        .id_dest(id_dest), .id_dest_we(id_dest_we), .id_is_load(id_is_load),
        .flush(flush), .stall(s0), .bubble(bb0), .issue(i0),
        .fwd_a(fa0), .fwd_b(fb0), .stall_cnt(c0)
    );

    hazard_stall_ctrl #(.WB_LAT(7), .FWD_EN(0), .CNT_W(16)) dut7 (
        .clk(clk), .rst_n(rst_n), .id_valid(id_valid),
        .id_src_a(id_src_a), .id_src_a_en(id_src_a_en),
        .id_src_b(id_src_b), .id_src_b_en(id_src_b_en),
        .id_dest(id_dest), .id_dest_we(id_dest_we), .id_is_load(id_is_load),
        .flush(flush), .stall(s7), .bubble(bb7), .issue(i7),
        .fwd_a(fa7), .fwd_b(fb7), .stall_cnt(c7)
    );

    task automatic drv(input logic v, input logic [2:0] sa, input logic sae,
                       input logic [2:0] sb, input logic sbe, input logic [2:0] d,
                       input logic we, input logic ld, input logic fl);
        id_valid = v; id_src_a = sa; id_src_a_en = sae;
        id_src_b = sb; id_src_b_en = sbe; id_dest = d;
        id_dest_we = we; id_is_load = ld; flush = fl;
    endtask

    task automatic idle();
        drv(1'b0, 3'd0, 1'b0, 3'd0, 1'b0, 3'd0, 1'b0, 1'b0, 1'b0);
    endtask

    // Cycles start 1 time unit after the falling edge; checks follow 1 unit later.
    task automatic next();
        @(negedge clk);
        #1;
    endtask

    task automatic do_reset();
        idle();
        rst_n = 1'b0;
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        #1;
    endtask

    task automatic test_reset();
        do_reset();
        #1;
        total++; if (s1 !== 1'b0) begin bad++; $display("FAIL reset_stall: got %0d want 0", s1); end
        total++; if (bb1 !== 1'b1) begin bad++; $display("FAIL reset_bubble: got %0d want 1", bb1); end
        total++; if (i1 !== 1'b0) begin bad++; $display("FAIL reset_issue: got %0d want 0", i1); end
        total++; if (c1 !== 16'd0) begin bad++; $display("FAIL reset_cnt: got %0d want 0", c1); end
        drv(1'b1, 3'd0, 1'b1, 3'd0, 1'b1, 3'd0, 1'b0, 1'b0, 1'b0);
        #1;
        total++; if (i1 !== 1'b1) begin bad++; $display("FAIL reset_r0_issue: got %0d want 1", i1); end
        total++; if (fa1 !== 3'd0 || fb1 !== 3'd0) begin bad++; $display("FAIL reset_fwd: got %0d/%0d want 0/0", fa1, fb1); end
        total++; if (s0 !== 1'b0) begin bad++; $display("FAIL reset_nofwd_stall: got %0d want 0", s0); end
        next();
    endtask

    task automatic test_alu_fwd();
        do_reset();
        drv(1'b1, 3'd0, 1'b0, 3'd0, 1'b0, 3'd3, 1'b1, 1'b0, 1'b0);
        #1;
        total++; if (i1 !== 1'b1) begin bad++; $display("FAIL alu_prod_issue: got %0d want 1", i1); end
        next();
        drv(1'b1, 3'd3, 1'b1, 3'd0, 1'b0, 3'd6, 1'b1, 1'b0, 1'b0);
        #1;
        total++; if (s1 !== 1'b0 || i1 !== 1'b1) begin bad++; $display("FAIL alu_use_issue: got stall=%0d issue=%0d want 0/1", s1, i1); end
        total++; if (fa1 !== 3'd1) begin bad++; $display("FAIL alu_fwd_a1: got %0d want 1", fa1); end
        total++; if (fb1 !== 3'd0) begin bad++; $display("FAIL alu_fwd_b_unused: got %0d want 0", fb1); end
        next();
        drv(1'b1, 3'd3, 1'b1, 3'd0, 1'b0, 3'd0, 1'b0, 1'b0, 1'b0);
        #1;
        total++; if (fa1 !== 3'd2) begin bad++; $display("FAIL alu_fwd_a2: got %0d want 2", fa1); end
        next();
    endtask

    task automatic test_last_stage();
        do_reset();
        drv(1'b1, 3'd0, 1'b0, 3'd0, 1'b0, 3'd7, 1'b1, 1'b0, 1'b0);
        next();
        idle();
        next();
        next();
        drv(1'b1, 3'd7, 1'b1, 3'd0, 1'b0, 3'd0, 1'b0, 1'b0, 1'b0);
        #1;
        total++; if (fa1 !== 3'd3 || s1 !== 1'b0) begin bad++; $display("FAIL last_fwd: got fwd=%0d stall=%0d want 3/0", fa1, s1); end
        total++; if (s0 !== 1'b1 || fa0 !== 3'd0) begin bad++; $display("FAIL last_nofwd_stall: got stall=%0d fwd=%0d want 1/0", s0, fa0); end
        next();
        total++; if (fa1 !== 3'd0) begin bad++; $display("FAIL last_gone_fwd: got %0d want 0", fa1); end
        total++; if (s0 !== 1'b0 || i0 !== 1'b1) begin bad++; $display("FAIL last_gone_issue: got stall=%0d issue=%0d want 0/1", s0, i0); end
        next();
    endtask

    task automatic test_load_use();
        do_reset();
        drv(1'b1, 3'd0, 1'b0, 3'd0, 1'b0, 3'd5, 1'b1, 1'b1, 1'b0);
        #1;
        total++; if (i1 !== 1'b1) begin bad++; $display("FAIL load_issue: got %0d want 1", i1); end
        next();
        drv(1'b1, 3'd0, 1'b0, 3'd5, 1'b1, 3'd0, 1'b0, 1'b0, 1'b0);
        #1;
        total++; if (s1 !== 1'b1 || bb1 !== 1'b1 || i1 !== 1'b0) begin bad++; $display("FAIL lu_stall: got s=%0d b=%0d i=%0d want 1/1/0", s1, bb1, i1); end
        total++; if (fb1 !== 3'd0 || c1 !== 16'd0) begin bad++; $display("FAIL lu_stall_fwd_cnt: got fwd=%0d cnt=%0d want 0/0", fb1, c1); end
        next();
        total++; if (s1 !== 1'b0 || i1 !== 1'b1) begin bad++; $display("FAIL lu_issue: got s=%0d i=%0d want 0/1", s1, i1); end
        total++; if (fb1 !== 3'd2) begin bad++; $display("FAIL lu_fwd_b: got %0d want 2", fb1); end
        total++; if (c1 !== 16'd1) begin bad++; $display("FAIL lu_cnt: got %0d want 1", c1); end
        next();
    endtask

    task automatic test_nofwd();
        do_reset();
        drv(1'b1, 3'd0, 1'b0, 3'd0, 1'b0, 3'd2, 1'b1, 1'b0, 1'b0);
        #1;
        total++; if (i0 !== 1'b1) begin bad++; $display("FAIL nf_prod_issue: got %0d want 1", i0); end
        next();
        drv(1'b1, 3'd0, 1'b0, 3'd2, 1'b1, 3'd0, 1'b0, 1'b0, 1'b0);
        for (int n = 0; n < 3; n++) begin
            #1;
            total++; if (s0 !== 1'b1 || bb0 !== 1'b1) begin bad++; $display("FAIL nf_stall%0d: got s=%0d b=%0d want 1/1", n, s0, bb0); end
            next();
        end
        #1;
        total++; if (s0 !== 1'b0 || i0 !== 1'b1) begin bad++; $display("FAIL nf_issue: got s=%0d i=%0d want 0/1", s0, i0); end
        total++; if (fb0 !== 3'd0) begin bad++; $display("FAIL nf_fwd_b: got %0d want 0", fb0); end
        total++; if (c0 !== 16'd3) begin bad++; $display("FAIL nf_cnt: got %0d want 3", c0); end
        next();
    endtask

    task automatic test_youngest();
        do_reset();
        drv(1'b1, 3'd0, 1'b0, 3'd0, 1'b0, 3'd4, 1'b1, 1'b0, 1'b0);
        next();
        next();
        drv(1'b1, 3'd4, 1'b1, 3'd4, 1'b1, 3'd0, 1'b0, 1'b0, 1'b0);
        #1;
        total++; if (fa1 !== 3'd1) begin bad++; $display("FAIL young_fwd_a: got %0d want 1", fa1); end
        total++; if (fb1 !== 3'd1) begin bad++; $display("FAIL young_fwd_b: got %0d want 1", fb1); end
        next();
    endtask

    task automatic test_flush();
        do_reset();
        drv(1'b1, 3'd0, 1'b0, 3'd0, 1'b0, 3'd1, 1'b1, 1'b1, 1'b0);
        next();
        drv(1'b1, 3'd1, 1'b1, 3'd0, 1'b0, 3'd2, 1'b1, 1'b0, 1'b1);
        #1;
        total++; if (s1 !== 1'b0 || i1 !== 1'b0 || bb1 !== 1'b1) begin bad++; $display("FAIL flush_outs: got s=%0d i=%0d b=%0d want 0/0/1", s1, i1, bb1); end
        next();
        drv(1'b1, 3'd2, 1'b1, 3'd1, 1'b1, 3'd0, 1'b0, 1'b0, 1'b0);
        #1;
        total++; if (fa1 !== 3'd0) begin bad++; $display("FAIL flush_no_entry: got %0d want 0", fa1); end
        total++; if (fb1 !== 3'd2 || s1 !== 1'b0) begin bad++; $display("FAIL flush_load_fwd: got fwd=%0d s=%0d want 2/0", fb1, s1); end
        total++; if (c1 !== 16'd0) begin bad++; $display("FAIL flush_cnt: got %0d want 0", c1); end
        next();
    endtask

    task automatic test_reset_mid();
        do_reset();
        drv(1'b1, 3'd0, 1'b0, 3'd0, 1'b0, 3'd1, 1'b1, 1'b1, 1'b0);
        next();
        drv(1'b1, 3'd1, 1'b1, 3'd0, 1'b0, 3'd1, 1'b1, 1'b1, 1'b0);
        #1;
        total++; if (s1 !== 1'b1) begin bad++; $display("FAIL rm_pre_stall: got %0d want 1", s1); end
        next();
        #1;
        total++; if (i1 !== 1'b1) begin bad++; $display("FAIL rm_pre_issue: got %0d want 1", i1); end
        next();
        drv(1'b1, 3'd1, 1'b1, 3'd0, 1'b0, 3'd0, 1'b0, 1'b0, 1'b0);
        total++; if (s1 !== 1'b1 || c1 !== 16'd1) begin bad++; $display("FAIL rm_before: got s=%0d cnt=%0d want 1/1", s1, c1); end
        rst_n = 1'b0;
        #1;
        total++; if (s1 !== 1'b0 || c1 !== 16'd0) begin bad++; $display("FAIL rm_async: got s=%0d cnt=%0d want 0/0", s1, c1); end
        rst_n = 1'b1;
        #1;
        total++; if (s1 !== 1'b0 || fa1 !== 3'd0 || i1 !== 1'b1) begin bad++; $display("FAIL rm_after: got s=%0d fwd=%0d i=%0d want 0/0/1", s1, fa1, i1); end
        total++; if (c1 !== 16'd0) begin bad++; $display("FAIL rm_cnt: got %0d want 0", c1); end
        next();
    endtask

    // WB_LAT=7 self-dependent instruction: 1 issue then 7 stalls every 8 cycles.
    task automatic test_saturate();
        do_reset();
        drv(1'b1, 3'd2, 1'b1, 3'd0, 1'b0, 3'd2, 1'b1, 1'b0, 1'b0);
        #1;
        total++; if (i7 !== 1'b1) begin bad++; $display("FAIL sat_first_issue: got %0d want 1", i7); end
        repeat (16) @(negedge clk);
        #1;
        total++; if (c7 !== 16'd14) begin bad++; $display("FAIL sat_early_cnt: got %0d want 14", c7); end
        repeat (74880) @(negedge clk);
        #1;
        total++; if (c7 !== 16'hFFFE) begin bad++; $display("FAIL sat_near_cnt: got %0h want fffe", c7); end
        repeat (8) @(negedge clk);
        #1;
        total++; if (c7 !== 16'hFFFF) begin bad++; $display("FAIL sat_hold_cnt: got %0h want ffff", c7); end
        idle();
        next();
    endtask

    initial begin
        @(negedge clk);
        #1;
        test_reset();
        test_alu_fwd();
        test_last_stage();
        test_load_use();
        test_nofwd();
        test_youngest();
        test_flush();
        test_reset_mid();
        test_saturate();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
